// File: rtl/gf163_pkg.sv
// Shared GF(2^163) definitions: field constants, element types, the
// converter state encoding and the reference arithmetic helpers.
package gf163_pkg;

  localparam int M        = 163;
  localparam int MUL_WAIT = 4;
  localparam int STATE_W  = 3;

  typedef logic [M-1:0]   gf_t;
  typedef logic [2*M-2:0] gf_wide_t;

  localparam gf_t GF_ZERO = '0;
  localparam gf_t GF_ONE  = gf_t'(1);
  // x^163 + x^7 + x^6 + x^3 + 1
  localparam logic [M:0] GF_POLY = {1'b1, 155'd0, 8'hC9};

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 3'd0,
    S_ZERO    = 3'd1,
    S_INV     = 3'd2,
    S_INV_REL = 3'd3,
    S_MUL     = 3'd4,
    S_MUL2    = 3'd5,
    S_WAIT    = 3'd6
  } ld_state_t;

  function automatic gf_t gf_reduce(input gf_wide_t c);
    gf_wide_t r;
    r = c;
    for (int i = 2*M-2; i >= M; i--) begin
      if (r[i]) r[i-M +: M+1] = r[i-M +: M+1] ^ GF_POLY;
    end
    return r[M-1:0];
  endfunction

  function automatic gf_wide_t gf_clmul(input gf_t a, input gf_t b);
    gf_wide_t p;
    p = '0;
    for (int i = 0; i < M; i++) begin
      if (b[i]) p = p ^ (gf_wide_t'(a) << i);
    end
    return p;
  endfunction

  function automatic gf_t gf_mul(input gf_t a, input gf_t b);
    return gf_reduce(gf_clmul(a, b));
  endfunction

  // Squaring in characteristic 2 just interleaves zeros before reduction.
  function automatic gf_t gf_sqr(input gf_t a);
    gf_wide_t s;
    s = '0;
    for (int i = 0; i < M; i++) s[2*i] = a[i];
    return gf_reduce(s);
  endfunction

endpackage

// File: rtl/gf2m_inv163.sv
// Fermat inverter a^(2^163-2), one square-and-multiply step per cycle.
// done stays high while start is held; start must drop before the next request.
module gf2m_inv163
  import gf163_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  gf_t  a,
  output gf_t  inv,
  output logic done
);

  typedef enum logic [1:0] {I_IDLE, I_RUN, I_DONE} inv_state_t;

  inv_state_t state;
  gf_t        a_q;
  logic [7:0] cnt;
  gf_t        step;

  // Exponent bits 162..1 are ones and bit 0 is zero, so the last step only squares.
  assign step = (cnt != 8'd0) ? gf_mul(gf_sqr(inv), a_q) : gf_sqr(inv);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= I_IDLE;
      a_q   <= '0;
      cnt   <= '0;
      inv   <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        I_IDLE: if (start) begin
          a_q   <= a;
          inv   <= GF_ONE;
          cnt   <= 8'(M-1);
          state <= I_RUN;
        end
        I_RUN: begin
          inv <= step;
          if (cnt == 8'd0) begin
            done  <= 1'b1;
            state <= I_DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        I_DONE: if (!start) begin
          done  <= 1'b0;
          state <= I_IDLE;
        end
        default: state <= I_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/gf2m_mult163.sv
// Fully pipelined GF(2^163) multiplier: operand, carry-less product and
// reduced product registers, so a new pair can be issued every cycle.
module gf2m_mult163
  import gf163_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  gf_t  a,
  input  gf_t  b,
  output gf_t  p
);

  gf_t      a_q;
  gf_t      b_q;
  gf_wide_t prod_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      p      <= '0;
    end else begin
      a_q    <= a;
      b_q    <= b;
      prod_q <= gf_clmul(a_q, b_q);
      p      <= gf_reduce(prod_q);
    end
  end

endmodule

// File: rtl/squerer_163.sv
// Combinational GF(2^163) squarer.
module squerer_163
  import gf163_pkg::*;
(
  input  gf_t a,
  output gf_t sq
);

  assign sq = gf_sqr(a);

endmodule

// File: rtl/ld_to_affine_163.sv
// Lopez-Dahab (X, Y, Z) to affine (X/Z, Y/Z^2) conversion over GF(2^163),
// sequencing the shared inverter, squarer and pipelined multiplier.
module ld_to_affine_163
  import gf163_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] X,
  input  logic [M-1:0] Y,
  input  logic [M-1:0] Z,
  output logic [M-1:0] x_aff,
  output logic [M-1:0] y_aff,
  output logic         inf,
  output logic         busy,
  output logic         done
);

  localparam logic [2:0] TAG_X = 3'(MUL_WAIT);
  localparam logic [2:0] TAG_Y = 3'(MUL_WAIT + 1);

  ld_state_t  state;
  gf_t        x_q;
  gf_t        y_q;
  gf_t        zi;
  gf_t        zi_sq;
  gf_t        op_a;
  gf_t        op_b;
  gf_t        prod;
  gf_t        x_res;
  gf_t        inv_out;
  logic       inv_start;
  logic       inv_done;
  logic [2:0] tag;

  gf2m_inv163 u_inv (
    .clk   (clk),
    .rst   (~rst_n),
    .start (inv_start),
    .a     (Z),
    .inv   (inv_out),
    .done  (inv_done)
  );

  squerer_163 u_sqr (
    .a  (zi),
    .sq (zi_sq)
  );

  gf2m_mult163 u_mul (
    .clk (clk),
    .rst (~rst_n),
    .a   (op_a),
    .b   (op_b),
    .p   (prod)
  );

  // tag counts edges since the x operands were issued; x is parked in x_res
  // so the visible outputs only ever change together on the done edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      zi        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      x_res     <= '0;
      tag       <= '0;
      inv_start <= 1'b0;
      x_aff     <= '0;
      y_aff     <= '0;
      inf       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          x_q  <= X;
          y_q  <= Y;
          busy <= 1'b1;
          inf  <= 1'b0;
          if (Z == GF_ZERO) begin
            state <= S_ZERO;
          end else begin
            inv_start <= 1'b1;
            state     <= S_INV;
          end
        end
        S_ZERO: begin
          x_aff <= GF_ZERO;
          y_aff <= GF_ZERO;
          inf   <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_INV: if (inv_done) begin
          zi        <= inv_out;
          inv_start <= 1'b0;
          state     <= S_INV_REL;
        end
        S_INV_REL: if (!inv_done) state <= S_MUL;
        S_MUL: begin
          op_a  <= x_q;
          op_b  <= zi;
          tag   <= 3'd1;
          state <= S_MUL2;
        end
        S_MUL2: begin
          op_a  <= y_q;
          op_b  <= zi_sq;
          tag   <= tag + 3'd1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          tag <= tag + 3'd1;
          if (tag == TAG_X) x_res <= prod;
          if (tag == TAG_Y) begin
            x_aff <= x_res;
            y_aff <= prod;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ld_to_affine_163.sv
// Scoreboard bench for ld_to_affine_163 with an independent bit-serial GF(2^163) model.
module tb_ld_to_affine_163;

  localparam int W       = 163;
  localparam int MAX_CYC = 400;

  typedef logic [W-1:0] elem_t;
  typedef struct {
    elem_t x;
    elem_t y;
    elem_t z;
    logic  inf;
  } exp_t;

  exp_t  sb[$];
  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  start = 1'b0;
  elem_t X = '0;
  elem_t Y = '0;
  elem_t Z = '0;
  elem_t x_aff, y_aff;
  logic  inf, busy, done;
  int    n_tests = 0;
  int    n_fail = 0;
  int    lat_ref = 0;
  logic  prev_done = 1'b0;

  always #5 clk = ~clk;

  ld_to_affine_163 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .X     (X),
    .Y     (Y),
    .Z     (Z),
    .x_aff (x_aff),
    .y_aff (y_aff),
    .inf   (inf),
    .busy  (busy),
    .done  (done)
  );

  // done must never be high on two consecutive samples
  always @(negedge clk) begin
    if (done && prev_done) begin
      n_fail++;
      $display("[TB] FAIL done_double_pulse at %0t: done high two cycles, required one", $time);
    end
    prev_done = done;
  end

  // MSB-first shift-and-add multiply, reducing by x^163 = x^7+x^6+x^3+1
  function automatic elem_t tb_mul(input elem_t a, input elem_t b);
    elem_t r;
    r = '0;
    for (int i = W-1; i >= 0; i--) begin
      r = r[W-1] ? ((r << 1) ^ elem_t'(8'hC9)) : (r << 1);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic elem_t rand_elem();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  function automatic elem_t rand_nz();
    elem_t v;
    v = rand_elem();
    if (v == '0) v = elem_t'(1);
    return v;
  endfunction

  task automatic start_conv(input elem_t xi, input elem_t yi, input elem_t zi);
    @(negedge clk);
    X = xi;
    Y = yi;
    Z = zi;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits from the sample just after the accept edge; cyc counts edges to done.
  task automatic wait_done(output int cyc, output int busy_cyc, output bit to, output bit inv_seen);
    cyc = 0;
    busy_cyc = 0;
    to = 1'b0;
    inv_seen = 1'b0;
    while (!done) begin
      if (busy) busy_cyc++;
      if (dut.inv_start) inv_seen = 1'b1;
      if (cyc >= MAX_CYC) begin
        to = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    if (to) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL done_timeout: no done within %0d cycles", MAX_CYC);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({x_aff, y_aff, inf, busy, done} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: x=%h y=%h inf=%b busy=%b done=%b, required all zero",
               x_aff, y_aff, inf, busy, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_z_one();
    exp_t e;
    int cyc, bc;
    bit to, iv;
    elem_t xi, yi;
    xi = elem_t'({21{8'h5A}});
    yi = elem_t'({11{16'h1234}});
    sb.push_back('{x: xi, y: yi, z: elem_t'(1), inf: 1'b0});
    start_conv(xi, yi, elem_t'(1));
    wait_done(cyc, bc, to, iv);
    e = sb.pop_front();
    if (to) return;
    n_tests++;
    if (x_aff !== e.x || y_aff !== e.y || inf !== e.inf) begin
      n_fail++;
      $display("[TB] FAIL z_one_value: x=%h y=%h inf=%b, required x=%h y=%h inf=%b",
               x_aff, y_aff, inf, e.x, e.y, e.inf);
    end
    n_tests++;
    if (cyc < 2 || cyc > 260) begin
      n_fail++;
      $display("[TB] FAIL z_one_latency: %0d cycles, required 2..260", cyc);
    end
    n_tests++;
    if (bc !== cyc || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL z_one_busy: busy high %0d cycles (busy=%b at done), required %0d and 0",
               bc, busy, cyc);
    end
    lat_ref = cyc;
  endtask

  task automatic test_zero();
    exp_t e;
    int cyc, bc;
    bit to, iv;
    sb.push_back('{x: '0, y: '0, z: '0, inf: 1'b1});
    start_conv(rand_elem(), rand_elem(), '0);
    wait_done(cyc, bc, to, iv);
    e = sb.pop_front();
    if (to) return;
    n_tests++;
    if (x_aff !== e.x || y_aff !== e.y || inf !== e.inf) begin
      n_fail++;
      $display("[TB] FAIL zero_value: x=%h y=%h inf=%b, required x=0 y=0 inf=1", x_aff, y_aff, inf);
    end
    // done lands on the edge right after the accept edge
    n_tests++;
    if (cyc !== 1) begin
      n_fail++;
      $display("[TB] FAIL zero_latency: %0d cycles, required 1", cyc);
    end
    n_tests++;
    if (iv !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL zero_inv_start: inverter start seen=%b, required 0", iv);
    end
  endtask

  task automatic test_unit_ratio();
    exp_t e;
    int cyc, bc;
    bit to, iv;
    elem_t z;
    for (int k = 0; k < 100; k++) begin
      z = rand_nz();
      sb.push_back('{x: elem_t'(1), y: elem_t'(1), z: z, inf: 1'b0});
      start_conv(z, tb_mul(z, z), z);
      wait_done(cyc, bc, to, iv);
      e = sb.pop_front();
      if (to) return;
      n_tests++;
      if (x_aff !== e.x || y_aff !== e.y || inf !== e.inf) begin
        n_fail++;
        $display("[TB] FAIL unit_ratio[%0d]: z=%h x=%h y=%h inf=%b, required x=1 y=1 inf=0",
                 k, z, x_aff, y_aff, inf);
      end
      n_tests++;
      if (cyc !== lat_ref) begin
        n_fail++;
        $display("[TB] FAIL unit_ratio_latency[%0d]: %0d cycles, required %0d", k, cyc, lat_ref);
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    int cyc, bc;
    bit to, iv;
    for (int k = 0; k < 6; k++) begin
      sb.push_back('{x: rand_elem(), y: rand_elem(), z: rand_nz(), inf: 1'b0});
      start_conv(sb[$].x, sb[$].y, sb[$].z);
      wait_done(cyc, bc, to, iv);
      e = sb.pop_front();
      if (to) return;
      n_tests++;
      if (tb_mul(x_aff, e.z) !== e.x || tb_mul(tb_mul(y_aff, e.z), e.z) !== e.y || inf !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL random[%0d]: x*Z=%h y*Z^2=%h inf=%b, required %h %h 0",
                 k, tb_mul(x_aff, e.z), tb_mul(tb_mul(y_aff, e.z), e.z), inf, e.x, e.y);
      end
    end
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    int cyc, bc, extra, late;
    bit to, iv;
    late = (lat_ref > 30) ? lat_ref - 23 : 5;
    sb.push_back('{x: rand_elem(), y: rand_elem(), z: rand_nz(), inf: 1'b0});
    start_conv(sb[$].x, sb[$].y, sb[$].z);
    repeat (20) @(negedge clk);
    X = rand_elem();
    Y = rand_elem();
    Z = rand_nz();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (late) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bc, to, iv);
    e = sb.pop_front();
    if (to) return;
    n_tests++;
    if (tb_mul(x_aff, e.z) !== e.x || tb_mul(tb_mul(y_aff, e.z), e.z) !== e.y) begin
      n_fail++;
      $display("[TB] FAIL busy_ignore_value: x*Z=%h y*Z^2=%h, required %h %h",
               tb_mul(x_aff, e.z), tb_mul(tb_mul(y_aff, e.z), e.z), e.x, e.y);
    end
    n_tests++;
    if (22 + late + cyc !== lat_ref) begin
      n_fail++;
      $display("[TB] FAIL busy_ignore_latency: %0d cycles, required %0d", 22 + late + cyc, lat_ref);
    end
    extra = 0;
    repeat (lat_ref + 5) begin
      @(negedge clk);
      if (done) extra++;
    end
    n_tests++;
    if (extra !== 0) begin
      n_fail++;
      $display("[TB] FAIL busy_ignore_queued: %0d extra done pulses, required 0", extra);
    end
  endtask

  task automatic check_async_clear(input string tag);
    n_tests++;
    if ({x_aff, y_aff, inf, busy, done} !== '0) begin
      n_fail++;
      $display("[TB] FAIL %s: x=%h y=%h inf=%b busy=%b done=%b, required all zero",
               tag, x_aff, y_aff, inf, busy, done);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int cyc, bc;
    bit to, iv;
    for (int phase = 0; phase < 2; phase++) begin
      start_conv(rand_elem(), rand_elem(), elem_t'(1));
      repeat ((phase == 0) ? 50 : lat_ref - 2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      if (phase == 0) check_async_clear("reset_mid_inv");
      else            check_async_clear("reset_mid_wait");
      @(negedge clk);
      rst_n = 1'b1;
      sb.push_back('{x: rand_elem(), y: rand_elem(), z: elem_t'(1), inf: 1'b0});
      start_conv(sb[$].x, sb[$].y, sb[$].z);
      wait_done(cyc, bc, to, iv);
      e = sb.pop_front();
      if (to) return;
      n_tests++;
      if (x_aff !== e.x || y_aff !== e.y || inf !== 1'b0 || cyc !== lat_ref) begin
        n_fail++;
        $display("[TB] FAIL reset_recover[%0d]: x=%h y=%h inf=%b lat=%0d, required x=%h y=%h inf=0 lat=%0d",
                 phase, x_aff, y_aff, inf, cyc, e.x, e.y, lat_ref);
      end
    end
  endtask

  task automatic test_held_start();
    exp_t e;
    elem_t lx, ly;
    int cyc;
    bit stable;
    @(negedge clk);
    sb.push_back('{x: rand_elem(), y: rand_elem(), z: rand_nz(), inf: 1'b0});
    X = sb[$].x;
    Y = sb[$].y;
    Z = sb[$].z;
    start = 1'b1;
    lx = x_aff;
    ly = y_aff;
    for (int k = 0; k < 3; k++) begin
      cyc = 0;
      stable = 1'b1;
      do begin
        @(negedge clk);
        cyc++;
        if (!done && (x_aff !== lx || y_aff !== ly)) stable = 1'b0;
      end while (!done && cyc < MAX_CYC);
      e = sb.pop_front();
      if (!done) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL held_timeout[%0d]: no done within %0d cycles", k, MAX_CYC);
        start = 1'b0;
        return;
      end
      n_tests++;
      if (tb_mul(x_aff, e.z) !== e.x || tb_mul(tb_mul(y_aff, e.z), e.z) !== e.y) begin
        n_fail++;
        $display("[TB] FAIL held_value[%0d]: x*Z=%h y*Z^2=%h, required %h %h",
                 k, tb_mul(x_aff, e.z), tb_mul(tb_mul(y_aff, e.z), e.z), e.x, e.y);
      end
      n_tests++;
      if (cyc < lat_ref) begin
        n_fail++;
        $display("[TB] FAIL held_gap[%0d]: %0d cycles between pulses, required >= %0d", k, cyc, lat_ref);
      end
      n_tests++;
      if (!stable) begin
        n_fail++;
        $display("[TB] FAIL held_stable[%0d]: outputs changed before done, required stable", k);
      end
      lx = x_aff;
      ly = y_aff;
      if (k < 2) begin
        sb.push_back('{x: rand_elem(), y: rand_elem(), z: rand_nz(), inf: 1'b0});
        X = sb[$].x;
        Y = sb[$].y;
        Z = sb[$].z;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_z_one();
    test_zero();
    test_unit_ratio();
    test_random();
    test_busy_ignore();
    test_reset_mid();
    test_held_start();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
